// File: rtl/decode_slot_arbiter.sv
// Decode/issue slot arbiter.
// Shares one registered pipeline slot among NumReq instruction sources.
// Grant precedence: group lock, then starvation forcing, then priority
// class, then plain round-robin. A flush empties the slot and drops lock and
// wait state but keeps the round-robin pointer.
module decode_slot_arbiter #(
  parameter int unsigned NumReq    = 3,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxWait   = 8,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic [NumReq-1:0]             req_valid_i,
  input  logic [NumReq-1:0]             req_last_i,
  input  logic [NumReq-1:0]             req_prio_i,
  input  logic [NumReq*DataWidth-1:0]   req_data_i,
  output logic [NumReq-1:0]             req_ready_o,
  output logic                          slot_valid_o,
  output logic [DataWidth-1:0]          slot_data_o,
  output logic [IdxWidth-1:0]           slot_idx_o,
  input  logic                          slot_ready_i,
  output logic                          lock_active_o
);

  localparam int unsigned WaitWidth = $clog2(MaxWait + 1);
  localparam logic [WaitWidth-1:0] WaitMax = WaitWidth'(MaxWait);
  localparam logic [IdxWidth-1:0]  LastIdx = IdxWidth'(NumReq - 1);

  logic                 slot_valid_q;
  logic [DataWidth-1:0] slot_data_q;
  logic [IdxWidth-1:0]  slot_idx_q;
  logic                 lock_q;
  logic [IdxWidth-1:0]  lock_idx_q;
  logic [IdxWidth-1:0]  rr_ptr_q;
  logic [WaitWidth-1:0] wait_q [NumReq];

  logic [NumReq-1:0]    starve_mask;
  logic [NumReq-1:0]    prio_mask;
  logic [NumReq-1:0]    cand_mask;
  logic                 rr_found;
  logic [IdxWidth-1:0]  rr_idx;
  logic                 sel_found;
  logic [IdxWidth-1:0]  sel_idx;
  logic                 accept;
  logic                 grant_en;
  logic [IdxWidth-1:0]  rr_next;

  // Candidate mask: starving requesters first, then priority class, then all valid
  always_comb begin
    starve_mask = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      starve_mask[i] = req_valid_i[i] && (wait_q[i] == WaitMax);
    end
    prio_mask = req_valid_i & req_prio_i;
    if (|starve_mask) begin
      cand_mask = starve_mask;
    end else if (|prio_mask) begin
      cand_mask = prio_mask;
    end else begin
      cand_mask = req_valid_i;
    end
  end

  // Round-robin scan of the candidate mask starting at rr_ptr
  always_comb begin
    int unsigned j;
    logic [IdxWidth-1:0] jj;
    j        = 0;
    jj       = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      j = 32'(rr_ptr_q) + k;
      if (j >= NumReq) begin
        j = j - NumReq;
      end
      jj = IdxWidth'(j);
      if (!rr_found && cand_mask[jj]) begin
        rr_found = 1'b1;
        rr_idx   = jj;
      end
    end
  end

  // Final selection: a held lock bypasses every other rule
  always_comb begin
    accept = !slot_valid_q || slot_ready_i;
    if (lock_q) begin
      sel_found = req_valid_i[lock_idx_q];
      sel_idx   = lock_idx_q;
    end else begin
      sel_found = rr_found;
      sel_idx   = rr_idx;
    end
    grant_en    = accept && !flush_i && sel_found;
    req_ready_o = '0;
    if (grant_en) begin
      req_ready_o[sel_idx] = 1'b1;
    end
    rr_next = (sel_idx == LastIdx) ? '0 : sel_idx + IdxWidth'(1);
  end

  // Output slot: loads on grant, drains on consume, invalidated by flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid_q <= 1'b0;
      slot_data_q  <= '0;
      slot_idx_q   <= '0;
    end else if (flush_i) begin
      slot_valid_q <= 1'b0;
    end else if (grant_en) begin
      slot_valid_q <= 1'b1;
      slot_data_q  <= req_data_i[sel_idx*DataWidth +: DataWidth];
      slot_idx_q   <= sel_idx;
    end else if (slot_ready_i) begin
      slot_valid_q <= 1'b0;
    end
  end

  // Group lock and round-robin pointer; lock-rule grants leave the pointer alone
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else if (flush_i) begin
      lock_q <= 1'b0;
    end else if (grant_en) begin
      if (lock_q) begin
        if (req_last_i[sel_idx]) begin
          lock_q <= 1'b0;
        end
      end else begin
        rr_ptr_q <= rr_next;
        if (!req_last_i[sel_idx]) begin
          lock_q     <= 1'b1;
          lock_idx_q <= sel_idx;
        end
      end
    end
  end

  // Per-requester saturating wait counters
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (rst_i || flush_i || !req_valid_i[i] || req_ready_o[i]) begin
        wait_q[i] <= '0;
      end else if (wait_q[i] != WaitMax) begin
        wait_q[i] <= wait_q[i] + WaitWidth'(1);
      end
    end
  end

  assign slot_valid_o  = slot_valid_q;
  assign slot_data_o   = slot_data_q;
  assign slot_idx_o    = slot_idx_q;
  assign lock_active_o = lock_q;

endmodule
